adder_stim_gen: RTL and testbench
=================================

ADDER_STIM_GEN -- requirements
Module: adder_stim_gen

Interface
REQ-001 Parameter N, 21, operand width in bits (pattern word is 2N bits).
REQ-002 Parameter PAYLOAD, 20, flits per packet (>=1).
REQ-003 Parameter GAP, 7, idle cycles between packets (>=0).
REQ-004 Parameter PACKETS, 10, packets per run (>=1).
REQ-005 Parameter STEP, 10, thermometer increment in bits (1..2N).
REQ-006 Parameter SEED, 32'hACE1, nonzero LFSR seed.
REQ-007 clk  input  1  single clock, rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 start  input  1  one-cycle run request, honoured only in IDLE or DONE.
REQ-010 mode  input  2  pattern select: 0 thermometer, 1 LFSR, 2 alternating all-0/all-1, 3 reserved (behaves as 0); sampled on accepted start.
REQ-011 out_ready  input  1  consumer ready.
REQ-012 input1  output  N  low half of pattern word W[N-1:0].
REQ-013 input2  output  N  high half W[2N-1:N].
REQ-014 out_valid  output  1  input1/input2 hold a valid flit.
REQ-015 sum  output  N  registered (input1+input2) mod 2^N.
REQ-016 cout  output  1  carry out of that addition.
REQ-017 sum_valid  output  1  sum/cout valid.
REQ-018 busy  output  1  high in SEND or GAP.
REQ-019 done  output  1  high in DONE.

Function
REQ-020 FSM states IDLE, SEND, GAP, DONE; start in IDLE/DONE -> SEND next cycle, clears flit/packet counters and pattern state.
REQ-021 In SEND out_valid=1; a beat is out_valid&out_ready; no beat -> input1/input2/pattern hold unchanged.
REQ-022 Each beat advances pattern one step; new word visible the cycle after the beat; first flit of run is the first step from the all-zero start state.
REQ-023 Thermometer: ones-count c fills from MSB, c=min(c+STEP,2N); at c=2N switch to drain, zeros-count z from MSB, z=min(z+STEP,2N); at z=2N switch to fill with c=0; pattern state persists across packets within a run.
REQ-024 LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1, seeded SEED on start, advanced once per step; W = LFSR output replicated LSB-first to 2N bits.
REQ-025 Alternate: W toggles all-ones/all-zeros each step, first flit all-ones.
REQ-026 After PAYLOAD beats: if packets sent < PACKETS and GAP>0 -> GAP; if GAP=0 -> stay SEND; last packet -> DONE.
REQ-027 GAP lasts exactly GAP cycles, out_valid=0, input1/input2 hold last flit, then SEND.
REQ-028 sum/cout register on every beat; sum_valid=1 the cycle after a beat, else 0 (latency 1).
REQ-029 start while busy is ignored; start in DONE restarts.
REQ-030 mode changes outside an accepted start have no effect.

Reset
REQ-031 rst_n low asynchronously forces IDLE and all outputs 0 (input1, input2, sum, cout, out_valid, sum_valid, busy, done), counters 0, LFSR to SEED.
REQ-032 Reset mid-run abandons the run; no flit completes after deassertion until a new start.

Structure
REQ-033 Shared package holds mode encodings and FSM state enum.
REQ-034 Pattern generation (thermometer/LFSR/alternate next-word logic plus state) is one sub-module, stim_pattern_gen.

Verification (N=4, STEP=3, PAYLOAD=4, GAP=2, PACKETS=2)
REQ-035 mode 0, ready=1, start -> input2/input1 per beat: E/0, F/C, F/F, 1/F, 0/3, 0/0, E/0, F/C; sum/cout 1 cycle later: E/0, B/1, E/1, 0/1.
REQ-036 Same run -> out_valid 4 cycles, low exactly 2 cycles, high 4 cycles, then done=1, busy=0.
REQ-037 mode 2, out_ready low for 3 cycles mid-packet -> words and counters hold, sum_valid 0 during stall, sequence resumes F/F, 0/0 unbroken.
REQ-038 start pulsed while busy -> no restart; start in DONE -> fresh run identical to first.
REQ-039 rst_n low mid-GAP -> all outputs 0 immediately (async), IDLE after release, nothing until start.
REQ-040 mode 1 run twice -> identical flit sequences; GAP=0 -> out_valid continuous for 8 beats.

Source files
------------

// File: rtl/adder_stim_gen_pkg.sv
// Shared encodings for the adder stimulus generator: pattern modes, FSM states
// and the LFSR step used by the pattern sub-module.
package adder_stim_gen_pkg;

   localparam logic [1:0] MODE_THERM = 2'd0;
   localparam logic [1:0] MODE_LFSR  = 2'd1;
   localparam logic [1:0] MODE_ALT   = 2'd2;
   localparam logic [1:0] MODE_RSVD  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Galois right-shift taps for x^32 + x^22 + x^2 + x + 1
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

   function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                           input int unsigned lim);
      return (a + b > lim) ? lim : (a + b);
   endfunction

endpackage

// File: rtl/stim_pattern_gen.sv
// Pattern word generator: thermometer, LFSR and alternating patterns.
// The registered word always reflects the current pattern state.
module stim_pattern_gen
   import adder_stim_gen_pkg::*;
#(
   parameter int          N    = 21,
   parameter int          STEP = 10,
   parameter logic [31:0] SEED = 32'hACE1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           init,
   input  logic           advance,
   input  logic [1:0]     mode,
   output logic [2*N-1:0] word
);

   localparam int W2 = 2 * N;
   localparam int CW = $clog2(W2 + 1);
   localparam logic [W2-1:0] ONES = '1;

   logic [1:0]    mode_q, mode_c;
   logic          drain_q, drain_c, drain_n;
   logic [CW-1:0] cnt_q, cnt_c, cnt_n;
   logic          alt_q, alt_c, alt_n;
   logic [31:0]   lfsr_q, lfsr_c, lfsr_n;
   logic [W2-1:0] rep, word_n;

   always_comb begin
      // init steps from the all-zero start state instead of the held one
      mode_c  = init ? mode : mode_q;
      drain_c = init ? 1'b0 : drain_q;
      cnt_c   = init ? '0 : cnt_q;
      alt_c   = init ? 1'b0 : alt_q;
      lfsr_c  = init ? SEED : lfsr_q;

      if (int'(cnt_c) == W2) begin
         drain_n = ~drain_c;
         cnt_n   = CW'(sat_add(0, STEP, W2));
      end else begin
         drain_n = drain_c;
         cnt_n   = CW'(sat_add(int'(cnt_c), STEP, W2));
      end

      alt_n  = ~alt_c;
      lfsr_n = lfsr_step(lfsr_c);

      rep = '0;
      for (int unsigned i = 0; i < W2; i++) begin
         rep[i] = lfsr_n[i % 32];
      end

      case (mode_c)
         MODE_LFSR: word_n = rep;
         MODE_ALT:  word_n = {W2{alt_n}};
         default:   word_n = drain_n ? (ONES >> cnt_n) : ~(ONES >> cnt_n);
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q  <= MODE_THERM;
         drain_q <= 1'b0;
         cnt_q   <= '0;
         alt_q   <= 1'b0;
         lfsr_q  <= SEED;
         word    <= '0;
      end else if (init || advance) begin
         mode_q  <= mode_c;
         drain_q <= drain_n;
         cnt_q   <= cnt_n;
         alt_q   <= alt_n;
         lfsr_q  <= lfsr_n;
         word    <= word_n;
      end
   end

endmodule

// File: rtl/adder_stim_gen.sv
// Packetised operand stimulus for an N-bit adder with a registered reference
// sum; runs PACKETS packets of PAYLOAD flits separated by GAP idle cycles.
module adder_stim_gen
   import adder_stim_gen_pkg::*;
#(
   parameter int          N       = 21,
   parameter int          PAYLOAD = 20,
   parameter int          GAP     = 7,
   parameter int          PACKETS = 10,
   parameter int          STEP    = 10,
   parameter logic [31:0] SEED    = 32'hACE1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [1:0]   mode,
   input  logic         out_ready,
   output logic [N-1:0] input1,
   output logic [N-1:0] input2,
   output logic         out_valid,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         sum_valid,
   output logic         busy,
   output logic         done
);

   localparam int FW = $clog2(PAYLOAD + 1);
   localparam int PW = $clog2(PACKETS + 1);
   localparam int GW = $clog2(GAP + 2);
   localparam bit HAS_GAP = (GAP > 0);

   state_e          state_q;
   logic [FW-1:0]   flit_q;
   logic [PW-1:0]   pkt_q;
   logic [GW-1:0]   gap_q;
   logic [2*N-1:0]  word;
   logic            start_ok, beat, last_flit, last_pkt, gap_end, advance;

   assign out_valid = (state_q == ST_SEND);
   assign busy      = (state_q == ST_SEND) || (state_q == ST_GAP);
   assign done      = (state_q == ST_DONE);
   assign input1    = word[N-1:0];
   assign input2    = word[2*N-1:N];

   assign start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign beat      = out_valid && out_ready;
   assign last_flit = (int'(flit_q) == PAYLOAD - 1);
   assign last_pkt  = (int'(pkt_q) == PACKETS - 1);
   assign gap_end   = (state_q == ST_GAP) && (int'(gap_q) == GAP - 1);

   // The step after a packet's last beat is deferred to the end of the gap so
   // the last flit stays on input1/input2 through GAP and DONE.
   assign advance = (beat && !(last_flit && (last_pkt || HAS_GAP))) || gap_end;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         flit_q  <= '0;
         pkt_q   <= '0;
         gap_q   <= '0;
      end else if (start_ok) begin
         state_q <= ST_SEND;
         flit_q  <= '0;
         pkt_q   <= '0;
         gap_q   <= '0;
      end else begin
         case (state_q)
            ST_SEND: begin
               if (beat) begin
                  if (last_flit) begin
                     flit_q <= '0;
                     pkt_q  <= pkt_q + PW'(1);
                     if (last_pkt) begin
                        state_q <= ST_DONE;
                     end else if (HAS_GAP) begin
                        state_q <= ST_GAP;
                        gap_q   <= '0;
                     end
                  end else begin
                     flit_q <= flit_q + FW'(1);
                  end
               end
            end
            ST_GAP: begin
               if (gap_end) state_q <= ST_SEND;
               else         gap_q   <= gap_q + GW'(1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum       <= '0;
         cout      <= 1'b0;
         sum_valid <= 1'b0;
      end else begin
         sum_valid <= beat;
         if (beat) begin
            {cout, sum} <= {1'b0, word[N-1:0]} + {1'b0, word[2*N-1:N]};
         end
      end
   end

   stim_pattern_gen #(
      .N    (N),
      .STEP (STEP),
      .SEED (SEED)
   ) u_pat (
      .clk     (clk),
      .rst_n   (rst_n),
      .init    (start_ok),
      .advance (advance),
      .mode    (mode),
      .word    (word)
   );

endmodule

// File: tb/tb_adder_stim_gen.sv
// Self-checking bench: two generators (GAP=2 and GAP=0) share stimulus and are
// compared every cycle against a flit-index model of the run.
module tb_adder_stim_gen;

   localparam int TN      = 4;
   localparam int W2      = 2 * TN;
   localparam int TSTEP   = 3;
   localparam int TPAY    = 4;
   localparam int TPKT    = 2;
   localparam logic [31:0] TSEED = 32'hACE1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [1:0] mode = 2'd0;
   logic       ready = 1'b1;
   logic       cmp_en = 1'b0;

   logic [TN-1:0] in1 [2];
   logic [TN-1:0] in2 [2];
   logic [TN-1:0] sm  [2];
   logic          co  [2];
   logic          ov  [2];
   logic          sv  [2];
   logic          bz  [2];
   logic          dn  [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   adder_stim_gen #(.N(TN), .PAYLOAD(TPAY), .GAP(2), .PACKETS(TPKT), .STEP(TSTEP), .SEED(TSEED)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .out_ready(ready),
      .input1(in1[0]), .input2(in2[0]), .out_valid(ov[0]), .sum(sm[0]), .cout(co[0]),
      .sum_valid(sv[0]), .busy(bz[0]), .done(dn[0]));

   adder_stim_gen #(.N(TN), .PAYLOAD(TPAY), .GAP(0), .PACKETS(TPKT), .STEP(TSTEP), .SEED(TSEED)) dut_g0 (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .out_ready(ready),
      .input1(in1[1]), .input2(in2[1]), .out_valid(ov[1]), .sum(sm[1]), .cout(co[1]),
      .sum_valid(sv[1]), .busy(bz[1]), .done(dn[1]));

   task automatic chk(input string nm, input int m, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, m, $time, act, exp);
      end
   endtask

   // k-th flit (0-based) of a run, straight from the pattern rules
   function automatic logic [7:0] flit_word(input int md, input int k);
      int L, p, c, v;
      logic [31:0] s, mask;
      int taps [4] = '{32, 22, 2, 1};
      if (md == 1) begin
         mask = '0;
         foreach (taps[i]) mask = mask | (32'd1 << (taps[i] - 1));
         s = TSEED;
         for (int j = 0; j <= k; j++) s = s[0] ? ((s >> 1) ^ mask) : (s >> 1);
         return s[7:0];
      end
      if (md == 2) return (k % 2 == 0) ? 8'hFF : 8'h00;
      L = (W2 + TSTEP - 1) / TSTEP;
      p = k % (2 * L);
      if (p < L) begin
         c = ((p + 1) * TSTEP > W2) ? W2 : (p + 1) * TSTEP;
         v = ((1 << c) - 1) << (W2 - c);
      end else begin
         c = ((p - L + 1) * TSTEP > W2) ? W2 : (p - L + 1) * TSTEP;
         v = (1 << (W2 - c)) - 1;
      end
      return 8'(v);
   endfunction

   function automatic logic [4:0] sum_of(input logic [7:0] w);
      return 5'(int'(w[3:0]) + int'(w[7:4]));
   endfunction

   // model state: phase 0 idle, 1 send, 2 gap, 3 done
   int         mph [2] = '{0, 0};
   int         mk  [2] = '{0, 0};
   int         mg  [2] = '{0, 0};
   int         mmd [2] = '{0, 0};
   logic [7:0] mw  [2] = '{8'h00, 8'h00};
   logic [4:0] msc [2] = '{5'h00, 5'h00};
   logic       msv [2] = '{1'b0, 1'b0};

   initial forever begin
      @(posedge clk or negedge rst_n);
      for (int m = 0; m < 2; m++) begin
         int g;
         logic bt;
         g = (m == 0) ? 2 : 0;
         if (!rst_n) begin
            mph[m] = 0; mk[m] = 0; mg[m] = 0; mw[m] = '0; msc[m] = '0; msv[m] = 1'b0;
         end else begin
            bt = (mph[m] == 1) && ready;
            msv[m] = bt;
            if (start && (mph[m] == 0 || mph[m] == 3)) begin
               mph[m] = 1; mmd[m] = int'(mode); mk[m] = 0; mw[m] = flit_word(mmd[m], 0);
            end else if (bt) begin
               msc[m] = sum_of(mw[m]);
               mk[m]++;
               if (mk[m] % TPAY == 0) begin
                  if (mk[m] == TPAY * TPKT) mph[m] = 3;
                  else if (g > 0) begin mph[m] = 2; mg[m] = 0; end
                  else mw[m] = flit_word(mmd[m], mk[m]);
               end else begin
                  mw[m] = flit_word(mmd[m], mk[m]);
               end
            end else if (mph[m] == 2) begin
               mg[m]++;
               if (mg[m] == g) begin mph[m] = 1; mw[m] = flit_word(mmd[m], mk[m]); end
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         for (int m = 0; m < 2; m++) begin
            chk("out_valid", m, 32'(ov[m]), 32'(mph[m] == 1));
            chk("busy",      m, 32'(bz[m]), 32'(mph[m] == 1 || mph[m] == 2));
            chk("done",      m, 32'(dn[m]), 32'(mph[m] == 3));
            chk("word",      m, 32'({in2[m], in1[m]}), 32'(mw[m]));
            chk("sum_valid", m, 32'(sv[m]), 32'(msv[m]));
            chk("cout_sum",  m, 32'({co[m], sm[m]}), 32'(msc[m]));
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_start(input logic [1:0] md);
      start = 1'b1; mode = md;
      @(posedge clk); #1;
      start = 1'b0; mode = 2'($urandom_range(0, 3));
   endtask

   task automatic wait_done(input int maxc);
      int n = 0;
      while (dn[0] !== 1'b1 && n < maxc) begin @(posedge clk); #1; n++; end
      chk("wait_done", 0, 32'(dn[0]), 32'd1);
   endtask

   task automatic chk_zero(input string tag);
      for (int m = 0; m < 2; m++) begin
         chk({tag, "_word"}, m, 32'({in2[m], in1[m]}), 32'd0);
         chk({tag, "_sum"},  m, 32'({co[m], sm[m]}), 32'd0);
         chk({tag, "_flags"}, m, 32'({ov[m], sv[m], bz[m], dn[m]}), 32'd0);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors", checks, errors);
      $fatal(1);
   end

   initial begin
      logic [7:0] exp_therm [8] = '{8'hE0, 8'hFC, 8'hFF, 8'h1F, 8'h03, 8'h00, 8'hE0, 8'hFC};
      logic [4:0] exp_sum   [4] = '{5'h0E, 5'h1B, 5'h1E, 5'h10};
      int n;

      for (int k = 0; k < 8; k++) chk("pin_therm", k, 32'(flit_word(0, k)), 32'(exp_therm[k]));
      for (int k = 0; k < 4; k++) chk("pin_sum", k, 32'(sum_of(exp_therm[k])), 32'(exp_sum[k]));
      chk("pin_alt0", 0, 32'(flit_word(2, 0)), 32'h0FF);
      chk("pin_alt1", 1, 32'(flit_word(2, 1)), 32'h000);
      chk("pin_lfsr0", 0, 32'(flit_word(1, 0)), 32'h073);
      chk("pin_lfsr1", 1, 32'(flit_word(1, 1)), 32'h03A);
      chk("pin_rsvd", 0, 32'(flit_word(3, 1)), 32'h0FC);

      repeat (2) @(posedge clk);
      #1;
      cmp_en = 1'b1;
      chk_zero("reset");
      rst_n = 1'b1;
      cyc(2);

      // thermometer run with literal spot checks on the first flit and sum
      ready = 1'b1;
      pulse_start(2'd0);
      chk("first_flit", 0, 32'({in2[0], in1[0]}), 32'hE0);
      cyc(1);
      chk("first_sum", 0, 32'({sv[0], co[0], sm[0]}), 32'h2E);
      wait_done(40);
      cyc(2);

      // alternating run with a three-cycle stall mid-packet
      pulse_start(2'd2);
      cyc(2);
      ready = 1'b0;
      cyc(3);
      ready = 1'b1;
      wait_done(40);

      // start while busy is ignored, start from DONE restarts
      pulse_start(2'd0);
      cyc(3);
      pulse_start(2'd1);
      wait_done(40);
      pulse_start(2'd0);
      wait_done(40);

      // LFSR twice
      pulse_start(2'd1);
      wait_done(40);
      pulse_start(2'd1);
      wait_done(40);

      // asynchronous reset in the middle of a gap
      pulse_start(2'd0);
      n = 0;
      while (!(bz[0] === 1'b1 && ov[0] === 1'b0) && n < 20) begin @(posedge clk); #1; n++; end
      chk("reach_gap", 0, 32'({bz[0], ov[0]}), 32'h2);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("async_rst");
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      cyc(5);
      chk_zero("post_rst");

      // randomized runs: random mode, ready and stray start pulses
      repeat (25) begin
         pulse_start(2'($urandom_range(0, 3)));
         n = 0;
         while (dn[0] !== 1'b1 && n < 80) begin
            ready = ($urandom_range(0, 3) != 0);
            start = ($urandom_range(0, 9) == 0);
            mode  = 2'($urandom_range(0, 3));
            @(posedge clk); #1;
            n++;
         end
         start = 1'b0;
         ready = 1'b1;
         chk("rand_done", 0, 32'(dn[0]), 32'd1);
         cyc($urandom_range(0, 3));
      end

      cyc(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
